// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer around an external combinational ALU with a 4x8-bit register file.
// Optional status flags are built when CPU_FLAGS_EN is defined; otherwise the flags are tied low.
module alu_sequencer (
  input  logic       clock,
  input  logic       nReset,
  input  logic       instrValid,
  output logic       instrReady,
  input  logic [2:0] instrOpcode,
  input  logic [1:0] instrDest,
  input  logic [1:0] instrSrcA,
  input  logic [1:0] instrSrcB,
  input  logic [7:0] instrImm,
  output logic [2:0] aluOpcode,
  output logic [7:0] aluOperandA,
  output logic [7:0] aluOperandB,
  input  logic [7:0] aluResult,
  output logic       done,
  output logic [7:0] doneData,
  input  logic [1:0] readAddr,
  output logic [7:0] readData,
  output logic       flagZero,
  output logic       flagNegative
);

  localparam logic [2:0] OP_LOADI = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXECUTE   = 2'd1,
    WRITEBACK = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] regfile [4];
  logic [7:0] result_reg;
  logic [2:0] op_q;
  logic [1:0] dest_q;
  logic [1:0] src_a_q;
  logic [1:0] src_b_q;
  logic [7:0] imm_q;
  logic       uses_alu;

  assign instrReady = (state == IDLE);
  assign readData   = regfile[readAddr];
  assign doneData   = done ? result_reg : 8'h00;
  assign uses_alu   = (op_q != OP_LOADI) && (op_q != OP_NOP);

  // Operands come from the regfile during EXECUTE, before any write of this instruction lands.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    aluOpcode   = 3'b000;
    aluOperandA = 8'h00;
    aluOperandB = 8'h00;
    if (state == EXECUTE && uses_alu) begin
      aluOpcode   = op_q;
      aluOperandA = regfile[src_a_q];
      aluOperandB = regfile[src_b_q];
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      done       <= 1'b0;
      result_reg <= 8'h00;
      op_q       <= 3'b000;
      dest_q     <= 2'b00;
      src_a_q    <= 2'b00;
      src_b_q    <= 2'b00;
      imm_q      <= 8'h00;
      // NOTE: the register file is small and must read 0 after reset, so it is reset like any flop.
      for (int i = 0; i < 4; i++) regfile[i] <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (instrValid) begin
            op_q    <= instrOpcode;
            dest_q  <= instrDest;
            src_a_q <= instrSrcA;
            src_b_q <= instrSrcB;
            imm_q   <= instrImm;
            state   <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (op_q == OP_LOADI)    result_reg <= imm_q;
          else if (op_q == OP_NOP) result_reg <= 8'h00;
          else                     result_reg <= aluResult;
          done  <= 1'b1;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (op_q != OP_NOP) regfile[dest_q] <= result_reg;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CPU_FLAGS_EN
  logic flag_zero_q;
  logic flag_neg_q;

  // Flags track the value written back; NOP leaves them untouched.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
    end else if (state == WRITEBACK && op_q != OP_NOP) begin
      flag_zero_q <= (result_reg == 8'h00);
      flag_neg_q  <= result_reg[7];
    end
  end

  assign flagZero     = flag_zero_q;
  assign flagNegative = flag_neg_q;
`else
  assign flagZero     = 1'b0;
  assign flagNegative = 1'b0;
`endif

endmodule
